// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one sram-like memory port between the instruction
// fetch requester and the data access requester, in-order response routing.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inst_req/addr         fetch request (always a 4-byte read)
//   inst_addr_ok/data_ok  fetch address accepted / fetch data returned
//   inst_rdata            fetch read data
//   data_req/wr/size/wstrb/addr/wdata   data request and payload
//   data_addr_ok/data_ok  data address accepted / data response
//   data_rdata            data read data
//   mem_*                 downstream request, mem_addr_ok/mem_data_ok/mem_rdata back
//   err_unexp_ok          sticky: response seen with nothing outstanding
//
// Build option: define MEM_ARB_RR_EN for round-robin instead of
// fixed data-over-inst priority.
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err_unexp_ok
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Outstanding-ID FIFO: 0 = inst, 1 = data
    logic [MAX_OUTSTANDING-1:0] ids;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              count;

    logic lock;
    logic lock_id;
    logic err;
    logic full;
    logic empty;
    logic gnt_id;
    logic push;
    logic pop;
    logic head;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;

    // Preferred requester flips away from whoever was just accepted
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (push)
            rr_ptr <= ~gnt_id;
    end

    always_comb begin
        if (lock)
            gnt_id = lock_id;
        else if (inst_req && data_req)
            gnt_id = rr_ptr;
        else
            gnt_id = data_req;
    end
`else
    assign gnt_id = lock ? lock_id : data_req;
`endif

    assign mem_req = !reset && !full && (gnt_id ? data_req : inst_req);
    assign push    = mem_req && mem_addr_ok;
    assign pop     = !reset && mem_data_ok && !empty;
    assign head    = ids[rd_ptr];

    assign inst_addr_ok = push && !gnt_id;
    assign data_addr_ok = push && gnt_id;
    assign inst_data_ok = pop && !head;
    assign data_data_ok = pop && head;
    assign inst_rdata   = reset ? '0 : mem_rdata;
    assign data_rdata   = reset ? '0 : mem_rdata;
    assign err_unexp_ok = err && !reset;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (mem_req) begin
            if (gnt_id) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ids     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= gnt_id;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            // Hold the grant on a requester until its address is taken
            if (push)
                lock <= 1'b0;
            else if (mem_req) begin
                lock    <= 1'b1;
                lock_id <= gnt_id;
            end
            if (mem_data_ok && empty)
                err <= 1'b1;
        end
    end

endmodule
